// File: rtl/painterengine_gpu_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : painterengine_gpu_reader_pkg
//  Description : Shared state codes, AXI constants and the 4 KB boundary
//                helper for the GPU display-stage read DMA.
//  Revision    : 1.0 - initial release
// ============================================================================
package painterengine_gpu_reader_pkg;

    // Debug-visible state codes; o_wire_state exposes these numerically.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_ADDR  = 4'd1,
        ST_DATA  = 4'd2,
        ST_DONE  = 4'd3,
        ST_ERROR = 4'd4
    } state_e;

    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam int unsigned BOUNDARY_BYTES = 4096;

    // True when a burst of 'words' 32-bit beats starting at page offset
    // 'offset' would run past the end of its 4 KB page. The sum is widened
    // so a huge word count cannot wrap back under the limit.
    function automatic logic crosses_boundary(input logic [11:0] offset,
                                              input logic [31:0] words);
        logic [34:0] end_byte;
        end_byte = {23'd0, offset} + {1'b0, words, 2'b00};
        return end_byte > 35'(BOUNDARY_BYTES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/painterengine_gpu_reader.sv
`default_nettype none
// ============================================================================
//  Module      : painterengine_gpu_reader
//  Description : AXI4 single-INCR-burst read master. One burst per reset
//                release; returned words are streamed to the display FIFO
//                with one cycle of registered latency. Reports done/error.
//  Revision    : 1.0 - initial release
// ============================================================================
module painterengine_gpu_reader
    import painterengine_gpu_reader_pkg::*;
#(
    parameter int MAX_BURST      = 64,
    parameter bit BOUNDARY_CHECK = 1'b1
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_resetn,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [31:0] o_wire_data,
    output logic        o_wire_data_valid,
    input  logic        i_wire_data_next,
    output logic [31:0] o_wire_m_axi_araddr,
    output logic [7:0]  o_wire_m_axi_arlen,
    output logic [2:0]  o_wire_m_axi_arsize,
    output logic [1:0]  o_wire_m_axi_arburst,
    output logic        o_wire_m_axi_arvalid,
    input  logic        i_wire_m_axi_arready,
    input  logic [31:0] i_wire_m_axi_rdata,
    input  logic [1:0]  i_wire_m_axi_rresp,
    input  logic        i_wire_m_axi_rlast,
    input  logic        i_wire_m_axi_rvalid,
    output logic        o_wire_m_axi_rready,
    output logic [31:0] o_wire_state
);

    state_e      state_q;
    logic [8:0]  beat_cnt_q;
    logic        drain_q;       // ERROR entered mid-burst and rlast not yet seen
    logic        done_q;
    logic        error_q;
    logic        data_valid_q;
    logic [31:0] data_q;
    logic [31:0] araddr_q;
    logic [7:0]  arlen_q;
    logic        arvalid_q;

    logic        cross_boundary;
    logic        len_bad;
    logic        addr_bad;
    logic        rready_comb;
    logic        beat_fire;
    logic        last_beat;
    logic        beat_ok;

    generate
        if (BOUNDARY_CHECK) begin : g_bound_chk
            assign cross_boundary = crosses_boundary(i_wire_address[11:0], i_wire_length);
        end else begin : g_no_bound_chk
            assign cross_boundary = 1'b0;
        end
    endgenerate

    assign len_bad   = i_wire_length > 32'(MAX_BURST);
    assign addr_bad  = i_wire_address[1:0] != 2'b00;
    assign beat_fire = i_wire_m_axi_rvalid & rready_comb;
    assign last_beat = beat_cnt_q == {1'b0, arlen_q};
    // A beat is clean only with OKAY and rlast exactly on the final beat.
    assign beat_ok   = (i_wire_m_axi_rresp == AXI_RESP_OKAY) &&
                       (i_wire_m_axi_rlast == last_beat);

    // RREADY follows the sink while streaming, and is forced high while
    // draining an aborted burst so the interconnect is never left stuck.
    always_comb begin
        rready_comb = 1'b0;
        case (state_q)
            ST_DATA:  rready_comb = i_wire_data_next;
            ST_ERROR: rready_comb = drain_q;
            default:  rready_comb = 1'b0;
        endcase
    end

    // Control FSM with beat counter and registered output stage.
    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= 9'd0;
            drain_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            data_valid_q <= 1'b0;
            data_q       <= 32'd0;
            araddr_q     <= 32'd0;
            arlen_q      <= 8'd0;
            arvalid_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_wire_length == 32'd0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (addr_bad || len_bad || cross_boundary) begin
                        state_q <= ST_ERROR;
                        error_q <= 1'b1;
                        drain_q <= 1'b0;
                    end else begin
                        state_q   <= ST_ADDR;
                        araddr_q  <= i_wire_address;
                        arlen_q   <= i_wire_length[7:0] - 8'd1;
                        arvalid_q <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    if (i_wire_m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_fire) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (!beat_ok) begin
                            // Faulty beat is dropped; keep draining unless it was the last.
                            state_q <= ST_ERROR;
                            error_q <= 1'b1;
                            drain_q <= !i_wire_m_axi_rlast;
                        end else begin
                            data_q       <= i_wire_m_axi_rdata;
                            data_valid_q <= 1'b1;
                            if (last_beat) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_ERROR: begin
                    if (beat_fire && i_wire_m_axi_rlast) begin
                        drain_q <= 1'b0;
                    end
                end
                default: begin
                    // DONE: hold until the next reset.
                end
            endcase
        end
    end

    assign o_wire_done          = done_q;
    assign o_wire_error         = error_q;
    assign o_wire_data          = data_q;
    assign o_wire_data_valid    = data_valid_q;
    assign o_wire_m_axi_araddr  = araddr_q;
    assign o_wire_m_axi_arlen   = arlen_q;
    assign o_wire_m_axi_arsize  = AXI_SIZE_4B;
    assign o_wire_m_axi_arburst = AXI_BURST_INCR;
    assign o_wire_m_axi_arvalid = arvalid_q;
    assign o_wire_m_axi_rready  = rready_comb;
    assign o_wire_state         = {28'd0, state_q};

endmodule
`default_nettype wire

// File: tb/tb_painterengine_gpu_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_painterengine_gpu_reader
//  Description : Self-checking bench for the GPU read DMA: AXI slave model,
//                launch-level reference model and per-cycle stream checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_painterengine_gpu_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr_i, len_i;
    logic        done, error, dv, dn;
    logic [31:0] data, araddr, state;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    painterengine_gpu_reader dut (
        .i_wire_clock         (clk),
        .i_wire_resetn        (rst_n),
        .i_wire_address       (addr_i),
        .i_wire_length        (len_i),
        .o_wire_done          (done),
        .o_wire_error         (error),
        .o_wire_data          (data),
        .o_wire_data_valid    (dv),
        .i_wire_data_next     (dn),
        .o_wire_m_axi_araddr  (araddr),
        .o_wire_m_axi_arlen   (arlen),
        .o_wire_m_axi_arsize  (arsize),
        .o_wire_m_axi_arburst (arburst),
        .o_wire_m_axi_arvalid (arvalid),
        .i_wire_m_axi_arready (arready),
        .i_wire_m_axi_rdata   (rdata),
        .i_wire_m_axi_rresp   (rresp),
        .i_wire_m_axi_rlast   (rlast),
        .i_wire_m_axi_rvalid  (rvalid),
        .o_wire_m_axi_rready  (rready),
        .o_wire_state         (state)
    );

    int errors = 0;
    int checks = 0;

    // Slave-side beat script and bookkeeping.
    logic [31:0] s_data [0:299];
    logic [1:0]  s_resp [0:299];
    logic        s_last [0:299];
    int          s_nbeats = 0;
    int          s_idx = 0;
    bit          hs_pend = 0, ar_pend = 0;
    int          ar_count = 0;
    logic [31:0] ar_addr_seen = '0;
    logic [7:0]  ar_len_seen = '0;
    bit          rv_rand = 0, ar_rand = 0;
    int          dn_mode = 0;

    // Launch-level expectations.
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    bit          exp_done = 0, exp_err = 0, exp_ar = 0;
    int          exp_total = 0;
    logic [31:0] exp_addr = '0;
    logic [7:0]  exp_len = '0;
    int          n_strobe = 0;
    int          arv_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // AXI slave: accepts AR, returns scripted beats, drives sink readiness.
    initial begin
        arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 0; dn = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                s_idx = 0; hs_pend = 0; ar_pend = 0; ar_count = 0;
                arready = 0; rvalid = 0; rlast = 0; rresp = '0; rdata = '0;
            end else begin
                if (ar_pend) ar_count++;
                if (hs_pend) s_idx++;
                arready = (ar_count == 0) ? (ar_rand ? 1'($urandom % 2) : 1'b1) : 1'b0;
                if (ar_count > 0 && s_idx < s_nbeats) begin
                    if (!rvalid || hs_pend) rvalid = rv_rand ? ($urandom % 4 != 0) : 1'b1;
                end else begin
                    rvalid = 0;
                end
                if (s_idx < s_nbeats && s_idx < 300) begin
                    rdata = s_data[s_idx]; rresp = s_resp[s_idx]; rlast = s_last[s_idx];
                end else begin
                    rdata = '0; rresp = '0; rlast = 0;
                end
            end
            case (dn_mode)
                0:       dn = 1'b1;
                1:       dn = ~dn;
                default: dn = 1'($urandom % 2);
            endcase
            #1;
            ar_pend = rst_n && arvalid && arready;
            if (ar_pend) begin
                ar_addr_seen = araddr;
                ar_len_seen  = arlen;
            end
            hs_pend = rst_n && rvalid && rready;
            if (rst_n) begin
                if (done)
                    chk("rready_in_done", 32'(rready), 32'd0);
                else if (error && ar_count > 0 && s_idx < s_nbeats)
                    chk("rready_drain", 32'(rready), 32'd1);
                else if (!error && ar_count > 0)
                    chk("rready_track", 32'(rready), 32'(dn));
            end
        end
    end

    // Stream checker: every strobe must carry the next expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (arvalid) arv_cycles++;
                chk("done_error_excl", 32'(done & error), 32'd0);
                if (dv) begin
                    n_strobe++;
                    got_q.push_back(data);
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_strobe: got data %h with no word expected", data);
                    end else begin
                        chk("strobe_data", data, exp_q.pop_front());
                    end
                    if (exp_done) chk("done_with_last", 32'(done), 32'(exp_q.size() == 0));
                    else          chk("no_done_on_err", 32'(done), 32'd0);
                end
            end
        end
    end

    // Hold reset, script the slave, derive expectations, then release.
    // fault: 0 none, 1 rresp=SLVERR on beat fb, 2 early rlast on beat fb,
    //        3 rlast missing on the final beat (slave sends two extra).
    task automatic start(input logic [31:0] a, input logic [31:0] len, input int fault,
                         input int fb, input bit rvr, input bit arr, input int dnm,
                         input bit seq, input logic [31:0] base);
        int n;
        rst_n = 0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_flags", {27'd0, done, error, dv, arvalid, rready}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd0);
        chk("rst_state", state, 32'd0);
        chk("rst_const", {27'd0, arsize, arburst}, 32'b01001);
        exp_q.delete(); got_q.delete();
        n_strobe = 0; arv_cycles = 0;
        rv_rand = rvr; ar_rand = arr; dn_mode = dnm;
        exp_done = 0; exp_err = 0; exp_ar = 0; s_nbeats = 0;
        exp_addr = a; exp_len = 8'(len - 32'd1);
        if (len == 0) begin
            exp_done = 1;
        end else if (a % 4 != 0 || len > 64 ||
                     longint'(a % 4096) + 4 * longint'(len) > 4096) begin
            exp_err = 1;
        end else begin
            exp_ar = 1;
            n = int'(len);
            for (int k = 0; k < n; k++) begin
                s_data[k] = seq ? base + 32'(k) : $urandom;
                s_resp[k] = 2'b00;
                s_last[k] = (k == n - 1);
            end
            s_nbeats = n;
            if (fault == 1) s_resp[fb] = 2'b10;
            if (fault == 2) begin s_last[fb] = 1'b1; s_nbeats = fb + 1; end
            if (fault == 3) begin
                s_last[n - 1] = 1'b0;
                for (int k = n; k < n + 2; k++) begin
                    s_data[k] = $urandom; s_resp[k] = 2'b00; s_last[k] = (k == n + 1);
                end
                s_nbeats = n + 2;
            end
            // Words are delivered in order until the first faulty beat.
            exp_done = 1;
            for (int k = 0; k < n; k++) begin
                if (s_resp[k] != 2'b00 || s_last[k] != (k == n - 1)) begin
                    exp_done = 0; exp_err = 1;
                    break;
                end
                exp_q.push_back(s_data[k]);
            end
        end
        exp_total = exp_q.size();
        addr_i = a; len_i = len;
        #1;
        rst_n = 1;
    endtask

    // Wait (bounded) for completion and the slave to drain, then check outcome.
    task automatic finish_launch(input string tag);
        bit ok = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk); #2;
            if ((done || error) && (ar_count == 0 || s_idx >= s_nbeats)) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout: done=%b error=%b beats=%0d/%0d", tag, done, error, s_idx, s_nbeats);
        end
        repeat (3) @(negedge clk);
        #2;
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_strobes"}, 32'(n_strobe), 32'(exp_total));
        chk({tag, "_rready_end"}, 32'(rready), 32'd0);
        chk({tag, "_state"}, state, exp_done ? 32'd3 : 32'd4);
        if (exp_ar) begin
            chk({tag, "_ar_count"}, 32'(ar_count), 32'd1);
            chk({tag, "_araddr"}, ar_addr_seen, exp_addr);
            chk({tag, "_arlen"}, 32'(ar_len_seen), 32'(exp_len));
            chk({tag, "_drained"}, 32'(s_idx), 32'(s_nbeats));
        end else begin
            chk({tag, "_no_arvalid"}, 32'(arv_cycles), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a, len;
        int sel, fault, fb;
        rst_n = 0; addr_i = '0; len_i = '0;

        // 1: basic 4-word burst with literal data.
        start(32'h1000_0000, 32'd4, 0, 0, 0, 0, 0, 1, 32'hA0);
        finish_launch("t1");
        chk("t1_arlen_lit", 32'(ar_len_seen), 32'd3);
        chk("t1_araddr_lit", ar_addr_seen, 32'h1000_0000);
        chk("t1_count_lit", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < got_q.size()) chk("t1_word_lit", got_q[i], 32'hA0 + 32'(i));

        // 2: sink toggles readiness every cycle, rvalid always high.
        start(32'h1000_0100, 32'd8, 0, 0, 0, 0, 1, 1, 32'hB0);
        finish_launch("t2");
        chk("t2_count_lit", 32'(n_strobe), 32'd8);

        // 3: zero length completes without any AR.
        start(32'h1000_0000, 32'd0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t3_done_2cyc", 32'(done), 32'd1);
        chk("t3_no_arvalid", 32'(arvalid), 32'd0);
        finish_launch("t3");

        // 4: request rejections and the exact-fit boundary cases.
        start(32'h0000_0FF8, 32'd4, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("t4_err_next_cycle", 32'(error), 32'd1);
        finish_launch("t4a");
        start(32'h0000_0002, 32'd1, 0, 0, 0, 0, 0, 0, 0);
        finish_launch("t4b");
        start(32'h1000_0FF0, 32'd4, 0, 0, 1, 1, 2, 0, 0);
        finish_launch("t4c");
        chk("t4c_done_lit", 32'(done), 32'd1);
        start(32'h2000_0000, 32'd65, 0, 0, 0, 0, 0, 0, 0);
        finish_launch("t4d");
        chk("t4d_err_lit", 32'(error), 32'd1);
        start(32'h2000_0F00, 32'd64, 0, 0, 1, 0, 2, 0, 0);
        finish_launch("t4e");

        // 5: SLVERR on beat 2; drain with the sink stalled.
        start(32'h3000_0000, 32'd4, 1, 1, 0, 0, 2, 0, 0);
        finish_launch("t5");
        chk("t5_count_lit", 32'(n_strobe), 32'd1);

        // 6: early rlast on beat 3, then a mid-burst global reset.
        start(32'h3000_0040, 32'd4, 2, 2, 0, 0, 0, 0, 0);
        finish_launch("t6a");
        chk("t6a_count_lit", 32'(n_strobe), 32'd2);
        start(32'h3000_0080, 32'd8, 0, 0, 1, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 200 && n_strobe < 2; cyc++) @(negedge clk);
        @(posedge clk);
        #2;
        chk("t6_mid_state", state, 32'd2);
        rst_n = 0;
        #1;
        chk("t6_async_clear", {27'd0, done, error, dv, arvalid, rready}, 32'd0);
        chk("t6_async_state", state, 32'd0);
        start(32'h3000_0100, 32'd6, 0, 0, 1, 1, 2, 0, 0);
        finish_launch("t6b");

        // Missing rlast on the final beat.
        start(32'h4000_0000, 32'd5, 3, 0, 1, 0, 2, 0, 0);
        finish_launch("t7");

        // Randomized launches.
        for (int it = 0; it < 25; it++) begin
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 4 == 0) a[11:0] = 12'(4096 - 4 * $urandom_range(1, 70));
            if ($urandom % 6 == 0) a[1:0] = 2'($urandom_range(1, 3));
            sel = int'($urandom % 10);
            len = (sel == 0) ? 32'd0 : (sel == 1) ? $urandom_range(65, 300) : $urandom_range(1, 64);
            fault = int'($urandom % 6);
            if (fault > 3) fault = 0;
            if (fault == 2 && len < 2) fault = 0;
            fb = 0;
            if (len >= 1 && len <= 64) begin
                if (fault == 1) fb = int'($urandom_range(0, int'(len) - 1));
                if (fault == 2) fb = int'($urandom_range(0, int'(len) - 2));
            end
            start(a, len, fault, fb, 1'($urandom % 2), 1'($urandom % 2),
                  int'($urandom % 3), 0, 0);
            finish_launch("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
